ov7670_fifo_capture: RTL and testbench
======================================

Name: ov7670_fifo_capture

Overview:
- Parametrised controller for the OV7670 camera and its AL422B frame FIFO.
- Sequences camera power-up and uses cam_vsync to write exactly one frame into the FIFO.
- Reads that frame back as a byte stream with valid/ready backpressure, driving rclk, oe_n, wrst_n and rrst_n.
- Sits between the camera header pins and downstream pixel logic; replaces the static camera tie-offs in the top level.

Parameters:
- PWRUP_CYCLES, 50_000, clocks for which camera reset/power-down is held after reset.
- RCLK_HALF, 2, clocks per rclk half-period, >=1.
- LINE_BYTES, 1280, bytes per line (e.g. 640 pixels x 2 bytes).
- FRAME_LINES, 480, lines per frame.
- WRST_CYCLES, 4, clocks for which wrst_n is held low at frame start.
- VSYNC_TIMEOUT, 5_000_000, clocks to wait for a vsync edge before flagging an error.

Ports:
- MAX10_CLK1_50  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cam_vsync  in  1  camera vsync, asynchronous; pass through a 2-flop synchroniser, then a rising-edge detector.
- cam_d  in  8  FIFO read data.
- capture_req  in  1  single-cycle request to capture one frame.
- continuous  in  1  when 1, re-arm automatically after each readout.
- out_ready  in  1  downstream accepts out_data.
- cam_reset_n, cam_pwdn, cam_we, cam_wrst_n, cam_rrst_n, cam_oe_n, cam_rclk  out  1 each  camera/FIFO controls, all registered.
- out_data  out  8  pixel byte.
- out_valid  out  1  out_data is valid.
- out_sol, out_eol, out_eof  out  1 each  first byte of line, last byte of line, last byte of frame; qualified by out_valid.
- idle  out  1  controller is in IDLE.
- timeout_err  out  1  sticky flag; cleared by the next accepted capture_req.
- frame_count  out  16  completed frames, wraps at 0xFFFF.

Behaviour:
- Reset values:
  - cam_pwdn=1, cam_reset_n=0, cam_we=0.
  - cam_wrst_n=1, cam_rrst_n=1, cam_oe_n=1, cam_rclk=0.
  - out_valid=0, out_data=0, all flags 0, idle=0, timeout_err=0, frame_count=0.
- Reset is asynchronous. Asserting it mid-operation aborts immediately and restarts from POWERUP.
- State machine:
  - POWERUP: count PWRUP_CYCLES, then cam_pwdn=0, cam_reset_n=1, go to IDLE.
  - IDLE: idle=1. When capture_req=1, or continuous=1, go to ARM. capture_req in any other state is ignored.
  - ARM: wait for vsync rising edge, then go to WRST.
    - A timeout counter runs; after VSYNC_TIMEOUT clocks, set timeout_err=1 and go to IDLE.
  - WRST:
    - cam_wrst_n=0 for WRST_CYCLES clocks.
    - cam_we=1 from the first WRST cycle.
    - Then go to WRITE.
  - WRITE:
    - cam_we stays 1 until the next vsync rising edge; then cam_we=0 and go to RRST.
    - Timeout applies with the same error path; cam_we is cleared on error.
  - RRST:
    - cam_rrst_n=0, cam_oe_n=0, then one full rclk period (RCLK_HALF high, then RCLK_HALF low).
    - Then cam_rrst_n=1, go to READ.
  - READ: per byte:
    - Drive rclk high for RCLK_HALF clocks.
    - On the last high clock, register cam_d into out_data and set out_valid=1.
    - Drive rclk low for RCLK_HALF clocks.
    - The next rising edge of rclk is held off while out_valid=1 and out_ready=0; rclk stays low during the stall.
  - Handshake:
    - A transfer occurs on a clock with out_valid & out_ready; out_valid drops after the transfer unless the next byte is captured on the same clock.
    - out_data and the flags stay stable while out_valid=1 and out_ready=0.
  - Counters:
    - x counts 0..LINE_BYTES-1; y counts 0..FRAME_LINES-1.
    - out_sol when x==0; out_eol when x==LINE_BYTES-1; out_eof when out_eol and y==FRAME_LINES-1.
  - DONE: entered after the eof byte is accepted.
    - cam_oe_n=1, frame_count+1.
    - Go to ARM if continuous=1, else IDLE.
- Counter widths are $clog2 of the respective limit. The ARM/WRITE timeout counter resets on every state entry.

Test Plan:
Bench parameters: PWRUP_CYCLES=10, RCLK_HALF=2, LINE_BYTES=4, FRAME_LINES=2, WRST_CYCLES=4, VSYNC_TIMEOUT=200.
- Power-up: release reset_n -> cam_pwdn=1, cam_reset_n=0 for 10 clocks, then 0/1; idle=1 on the next clock.
- Single capture:
  - Stimulus: capture_req pulse, then vsync rising edges 50 clocks apart.
  - Required: wrst_n low exactly 4 clocks; we=1 from the first WRST clock until the second edge.
  - Required: 8 bytes from a FIFO model (0x00..0x07) with out_sol on 0x00/0x04, out_eol on 0x03/0x07, out_eof on 0x07 only; frame_count=1; idle=1.
- Backpressure: out_ready low for 20 clocks on byte 2 -> rclk stays low; out_data=0x02 held; no byte lost or duplicated.
- Timeout: capture_req with no vsync -> timeout_err=1 after 200 clocks, idle=1, cam_we=0.
- Continuous mode: continuous=1, 3 frames -> frame_count=3; no idle cycles between frames.
- Mid-read reset: assert reset_n=0 during byte 5 -> all outputs return to reset values asynchronously; frame_count=0.

Source files
------------

// File: rtl/ov7670_fifo_capture.sv
// OV7670 + AL422B frame FIFO controller: camera power-up, one-frame capture gated by vsync,
// and paced FIFO readout as a valid/ready byte stream with line/frame markers.
module ov7670_fifo_capture #(
    parameter int PWRUP_CYCLES  = 50_000,
    parameter int RCLK_HALF     = 2,
    parameter int LINE_BYTES    = 1280,
    parameter int FRAME_LINES   = 480,
    parameter int WRST_CYCLES   = 4,
    parameter int VSYNC_TIMEOUT = 5_000_000
) (
    input  logic        MAX10_CLK1_50,
    input  logic        reset_n,
    input  logic        cam_vsync,
    input  logic [7:0]  cam_d,
    input  logic        capture_req,
    input  logic        continuous,
    input  logic        out_ready,
    output logic        cam_reset_n,
    output logic        cam_pwdn,
    output logic        cam_we,
    output logic        cam_wrst_n,
    output logic        cam_rrst_n,
    output logic        cam_oe_n,
    output logic        cam_rclk,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_sol,
    output logic        out_eol,
    output logic        out_eof,
    output logic        idle,
    output logic        timeout_err,
    output logic [15:0] frame_count
);

    localparam int CNT_MAX = (PWRUP_CYCLES > WRST_CYCLES)
                           ? ((PWRUP_CYCLES > RCLK_HALF) ? PWRUP_CYCLES : RCLK_HALF)
                           : ((WRST_CYCLES > RCLK_HALF) ? WRST_CYCLES : RCLK_HALF);
    localparam int CW = (CNT_MAX > 1)       ? $clog2(CNT_MAX)       : 1;
    localparam int TW = (VSYNC_TIMEOUT > 1) ? $clog2(VSYNC_TIMEOUT) : 1;
    localparam int XW = (LINE_BYTES > 1)    ? $clog2(LINE_BYTES)    : 1;
    localparam int YW = (FRAME_LINES > 1)   ? $clog2(FRAME_LINES)   : 1;

    localparam logic [CW-1:0] PWRUP_LD = CW'(PWRUP_CYCLES - 1);
    localparam logic [CW-1:0] WRST_LD  = CW'(WRST_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LD  = CW'(RCLK_HALF - 1);
    localparam logic [TW-1:0] TMO_LD   = TW'(VSYNC_TIMEOUT - 1);
    localparam logic [XW-1:0] X_LAST   = XW'(LINE_BYTES - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(FRAME_LINES - 1);

    // state   | meaning
    // POWERUP | camera held in reset/power-down for PWRUP_CYCLES
    // IDLE    | waiting for capture_req or continuous
    // ARM     | waiting for vsync rise that starts the frame (timeout guarded)
    // WRST    | FIFO write pointer reset, write enable already on
    // WRITE   | camera filling FIFO until the next vsync rise (timeout guarded)
    // RRST    | FIFO read pointer reset with one full rclk period
    // READ    | one rclk per byte, paced by out_ready
    // DONE    | frame delivered, count it and re-arm or go idle
    typedef enum logic [2:0] {
        S_POWERUP, S_IDLE, S_ARM, S_WRST, S_WRITE, S_RRST, S_READ, S_DONE
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [TW-1:0]   tmo_q;
    logic [XW-1:0]   x_q;
    logic [YW-1:0]   y_q;
    logic            last_q;
    logic            rr_hi_q;
    logic            vs_s1_q, vs_s2_q, vs_s3_q;
    logic            vs_rise;

    logic            cam_reset_n_q, cam_pwdn_q, cam_we_q, cam_wrst_n_q;
    logic            cam_rrst_n_q, cam_oe_n_q, rclk_q;
    logic [7:0]      out_data_q;
    logic            out_valid_q, out_sol_q, out_eol_q, out_eof_q;
    logic            idle_q, timeout_err_q;
    logic [15:0]     frame_count_q;

    assign vs_rise = vs_s2_q & ~vs_s3_q;

    always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_POWERUP;
            cnt_q         <= PWRUP_LD;
            tmo_q         <= TMO_LD;
            x_q           <= '0;
            y_q           <= '0;
            last_q        <= 1'b0;
            rr_hi_q       <= 1'b0;
            vs_s1_q       <= 1'b0;
            vs_s2_q       <= 1'b0;
            vs_s3_q       <= 1'b0;
            cam_reset_n_q <= 1'b0;
            cam_pwdn_q    <= 1'b1;
            cam_we_q      <= 1'b0;
            cam_wrst_n_q  <= 1'b1;
            cam_rrst_n_q  <= 1'b1;
            cam_oe_n_q    <= 1'b1;
            rclk_q        <= 1'b0;
            out_data_q    <= 8'h00;
            out_valid_q   <= 1'b0;
            out_sol_q     <= 1'b0;
            out_eol_q     <= 1'b0;
            out_eof_q     <= 1'b0;
            idle_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            frame_count_q <= 16'h0000;
        end else begin
            vs_s1_q <= cam_vsync;
            vs_s2_q <= vs_s1_q;
            vs_s3_q <= vs_s2_q;

            case (state_q)
                S_POWERUP: begin
                    if (cnt_q == '0) begin
                        cam_pwdn_q    <= 1'b0;
                        cam_reset_n_q <= 1'b1;
                        idle_q        <= 1'b1;
                        state_q       <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_IDLE: begin
                    if (capture_req || continuous) begin
                        if (capture_req) timeout_err_q <= 1'b0;
                        idle_q  <= 1'b0;
                        tmo_q   <= TMO_LD;
                        state_q <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (vs_rise) begin
                        cam_wrst_n_q <= 1'b0;
                        cam_we_q     <= 1'b1;
                        cnt_q        <= WRST_LD;
                        state_q      <= S_WRST;
                    end else if (tmo_q == '0) begin
                        timeout_err_q <= 1'b1;
                        idle_q        <= 1'b1;
                        state_q       <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q - 1'b1;
                    end
                end
                S_WRST: begin
                    if (cnt_q == '0) begin
                        cam_wrst_n_q <= 1'b1;
                        tmo_q        <= TMO_LD;
                        state_q      <= S_WRITE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_WRITE: begin
                    if (vs_rise) begin
                        cam_we_q     <= 1'b0;
                        cam_rrst_n_q <= 1'b0;
                        cam_oe_n_q   <= 1'b0;
                        rclk_q       <= 1'b0;
                        cnt_q        <= '0;
                        rr_hi_q      <= 1'b0;
                        x_q          <= '0;
                        y_q          <= '0;
                        last_q       <= 1'b0;
                        state_q      <= S_RRST;
                    end else if (tmo_q == '0) begin
                        cam_we_q      <= 1'b0;
                        timeout_err_q <= 1'b1;
                        idle_q        <= 1'b1;
                        state_q       <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q - 1'b1;
                    end
                end
                S_RRST: begin
                    // rrst_n is low a full clock before rclk rises so the FIFO sees it with setup
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (!rclk_q && !rr_hi_q) begin
                        rclk_q  <= 1'b1;
                        rr_hi_q <= 1'b1;
                        cnt_q   <= HALF_LD;
                    end else if (rclk_q) begin
                        rclk_q <= 1'b0;
                        cnt_q  <= HALF_LD;
                    end else begin
                        cam_rrst_n_q <= 1'b1;
                        cnt_q        <= '0;
                        state_q      <= S_READ;
                    end
                end
                S_READ: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        if (out_eof_q) state_q <= S_DONE;
                    end
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (rclk_q) begin
                        // end of the high phase: FIFO output has settled since the rising edge
                        rclk_q      <= 1'b0;
                        cnt_q       <= HALF_LD;
                        out_data_q  <= cam_d;
                        out_valid_q <= 1'b1;
                        out_sol_q   <= (x_q == '0);
                        out_eol_q   <= (x_q == X_LAST);
                        out_eof_q   <= (x_q == X_LAST) && (y_q == Y_LAST);
                        if (x_q == X_LAST) begin
                            x_q <= '0;
                            if (y_q == Y_LAST) begin
                                y_q    <= '0;
                                last_q <= 1'b1;
                            end else begin
                                y_q <= y_q + 1'b1;
                            end
                        end else begin
                            x_q <= x_q + 1'b1;
                        end
                    end else if (!last_q && !(out_valid_q && !out_ready)) begin
                        rclk_q <= 1'b1;
                        cnt_q  <= HALF_LD;
                    end
                end
                S_DONE: begin
                    cam_oe_n_q    <= 1'b1;
                    frame_count_q <= frame_count_q + 1'b1;
                    last_q        <= 1'b0;
                    if (continuous) begin
                        tmo_q   <= TMO_LD;
                        state_q <= S_ARM;
                    end else begin
                        idle_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_POWERUP;
            endcase
        end
    end

    assign cam_reset_n = cam_reset_n_q;
    assign cam_pwdn    = cam_pwdn_q;
    assign cam_we      = cam_we_q;
    assign cam_wrst_n  = cam_wrst_n_q;
    assign cam_rrst_n  = cam_rrst_n_q;
    assign cam_oe_n    = cam_oe_n_q;
    assign cam_rclk    = rclk_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_sol     = out_sol_q;
    assign out_eol     = out_eol_q;
    assign out_eof     = out_eof_q;
    assign idle        = idle_q;
    assign timeout_err = timeout_err_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_ov7670_fifo_capture.sv
// Directed bench for ov7670_fifo_capture with a small AL422B read-side model.
`timescale 1ns/1ps
module tb_ov7670_fifo_capture;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cam_vsync = 1'b0;
    logic [7:0]  cam_d = 8'h00;
    logic        capture_req = 1'b0;
    logic        continuous = 1'b0;
    logic        out_ready = 1'b1;
    logic        cam_reset_n, cam_pwdn, cam_we, cam_wrst_n, cam_rrst_n, cam_oe_n, cam_rclk;
    logic [7:0]  out_data;
    logic        out_valid, out_sol, out_eol, out_eof, idle, timeout_err;
    logic [15:0] frame_count;

    int checks = 0;
    int errors = 0;

    // {sol, eol, eof, data} for one 4x2 frame
    localparam logic [10:0] EXP [8] = '{11'h400, 11'h001, 11'h002, 11'h203,
                                        11'h404, 11'h005, 11'h006, 11'h307};

    ov7670_fifo_capture #(
        .PWRUP_CYCLES(10), .RCLK_HALF(2), .LINE_BYTES(4), .FRAME_LINES(2),
        .WRST_CYCLES(4), .VSYNC_TIMEOUT(200)
    ) dut (
        .MAX10_CLK1_50(clk), .reset_n(reset_n), .cam_vsync(cam_vsync), .cam_d(cam_d),
        .capture_req(capture_req), .continuous(continuous), .out_ready(out_ready),
        .cam_reset_n(cam_reset_n), .cam_pwdn(cam_pwdn), .cam_we(cam_we),
        .cam_wrst_n(cam_wrst_n), .cam_rrst_n(cam_rrst_n), .cam_oe_n(cam_oe_n),
        .cam_rclk(cam_rclk), .out_data(out_data), .out_valid(out_valid),
        .out_sol(out_sol), .out_eol(out_eol), .out_eof(out_eof), .idle(idle),
        .timeout_err(timeout_err), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    // FIFO read side: pointer reset on rclk rise while rrst_n low, else one byte per rise
    logic [7:0] rptr = 8'h00;
    int rclk_rises = 0;
    always @(posedge cam_rclk) begin
        rclk_rises++;
        if (!cam_rrst_n) rptr = 8'h00;
        else if (!cam_oe_n) begin
            cam_d = rptr;
            rptr++;
        end
    end

    logic [10:0] got_q[$];
    int wrst_low = 0, we_hi = 0, idle_clks = 0;
    logic wrst_prev = 1'b1;
    logic we_at_wrst = 1'b0;
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) got_q.push_back({out_sol, out_eol, out_eof, out_data});
        if (!cam_wrst_n) wrst_low++;
        if (cam_we) we_hi++;
        if (idle) idle_clks++;
        if (!cam_wrst_n && wrst_prev) we_at_wrst = cam_we;
        wrst_prev = cam_wrst_n;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic vsync_pulse();
        cam_vsync = 1'b1;
        tick(5);
        cam_vsync = 1'b0;
    endtask

    task automatic pulse_capture();
        capture_req = 1'b1;
        tick(1);
        capture_req = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit && !idle; i++) tick(1);
    endtask

    task automatic check_bytes(input string pfx, input int base, input int n);
        chk({pfx, "_count"}, 32'(got_q.size() - base), 32'(n));
        for (int i = 0; i < n; i++)
            if (base + i < got_q.size())
                chk($sformatf("%s_b%0d", pfx, i), 32'(got_q[base + i]), 32'(EXP[i % 8]));
    endtask

    task automatic check_reset_vals(input string pfx);
        chk({pfx, "_ctl"}, 32'({cam_pwdn, cam_reset_n, cam_we, cam_wrst_n, cam_rrst_n, cam_oe_n,
                                cam_rclk, out_valid, out_sol, out_eol, out_eof, idle, timeout_err}),
            32'h1380);
        chk({pfx, "_data"}, 32'(out_data), 32'h0);
        chk({pfx, "_fc"}, 32'(frame_count), 32'h0);
    endtask

    initial begin
        int base, w0, e0, r0, i0;

        tick(3);
        check_reset_vals("rst");
        reset_n = 1'b1;
        tick(9);
        chk("pwrup_hold", {cam_pwdn, cam_reset_n}, 2'b10);
        tick(1);
        chk("pwrup_release", {cam_pwdn, cam_reset_n}, 2'b01);
        tick(1);
        chk("pwrup_idle", idle, 1);

        // single capture
        base = got_q.size();
        w0 = wrst_low;
        e0 = we_hi;
        pulse_capture();
        chk("arm_not_idle", idle, 0);
        tick(10);
        vsync_pulse();
        tick(45);
        vsync_pulse();
        wait_idle(300);
        chk("f1_idle", idle, 1);
        chk("f1_wrst_clks", 32'(wrst_low - w0), 4);
        chk("f1_we_clks", 32'(we_hi - e0), 50);
        chk("f1_we_at_wrst", we_at_wrst, 1);
        chk("f1_fc", frame_count, 1);
        chk("f1_oe_n", cam_oe_n, 1);
        check_bytes("f1", base, 8);

        // backpressure on byte 2
        base = got_q.size();
        pulse_capture();
        tick(10);
        vsync_pulse();
        tick(45);
        vsync_pulse();
        for (int i = 0; i < 100 && !(out_valid && out_data == 8'h01); i++) tick(1);
        chk("bp_b1_seen", out_data, 8'h01);
        tick(1);
        out_ready = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) tick(1);
        chk("bp_b2_valid", out_valid, 1);
        chk("bp_b2_data", out_data, 8'h02);
        r0 = rclk_rises;
        tick(20);
        chk("bp_hold_data", out_data, 8'h02);
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_rclk_low", cam_rclk, 0);
        chk("bp_no_rclk", 32'(rclk_rises - r0), 0);
        out_ready = 1'b1;
        wait_idle(300);
        chk("bp_fc", frame_count, 2);
        check_bytes("bp", base, 8);

        // vsync timeout
        pulse_capture();
        tick(194);
        chk("tmo_early", timeout_err, 0);
        tick(10);
        chk("tmo_err", timeout_err, 1);
        chk("tmo_idle", idle, 1);
        chk("tmo_we", cam_we, 0);

        // continuous, three frames
        continuous = 1'b1;
        pulse_capture();
        chk("cont_err_cleared", timeout_err, 0);
        base = got_q.size();
        i0 = idle_clks;
        tick(10);
        repeat (6) begin
            vsync_pulse();
            tick(55);
        end
        for (int i = 0; i < 200 && frame_count != 16'd5; i++) tick(1);
        chk("cont_fc", frame_count, 5);
        chk("cont_no_idle", 32'(idle_clks - i0), 0);
        check_bytes("cont", base, 24);
        continuous = 1'b0;
        wait_idle(300);
        chk("cont_exit_idle", idle, 1);

        // reset in the middle of readout
        pulse_capture();
        tick(10);
        vsync_pulse();
        tick(45);
        vsync_pulse();
        for (int i = 0; i < 100 && !(out_valid && out_data == 8'h05); i++) tick(1);
        chk("mid_b5_seen", out_data, 8'h05);
        #2 reset_n = 1'b0;
        #1 check_reset_vals("mid_rst");
        tick(2);
        reset_n = 1'b1;
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
